// File: rtl/int_issue_queue_pkg.sv
// Shared backend types for the integer issue path: the renamed micro-op
// payload and the ROB age compare used by every flush consumer.
package int_issue_queue_pkg;

  localparam int PREG_W        = 6;   // physical register index width
  localparam int ROB_SIZE_LOG  = 5;   // ROB index width (wrap flag kept separately)
  localparam int PC_W          = 32;
  localparam int IMM_W         = 32;
  localparam int CX_TYPE_W     = 3;
  localparam int ALU_TYPE_W    = 4;
  localparam int MULDIV_TYPE_W = 4;

  typedef logic [PREG_W-1:0]        preg_t;
  typedef logic [ROB_SIZE_LOG-1:0]  robidx_t;
  typedef logic [CX_TYPE_W-1:0]     cx_type_t;
  typedef logic [ALU_TYPE_W-1:0]    alu_type_t;
  typedef logic [MULDIV_TYPE_W-1:0] muldiv_type_t;

  typedef struct packed {
    preg_t              prd;
    preg_t              prs1;
    preg_t              prs2;
    logic               src1_ready;
    logic               src2_ready;
    logic [IMM_W-1:0]   imm;
    logic               need_to_wb;
    cx_type_t           cx_type;
    logic               is_unsigned;
    alu_type_t          alu_type;
    logic               is_word;
    logic               is_imm;
    muldiv_type_t       muldiv_type;
    logic [PC_W-1:0]    pc;
    logic               robidx_flag;
    robidx_t            robidx;
  } int_uop_t;

  // True when ROB position a is strictly younger than ROB position b.
  // Differing wrap flags invert the plain index compare.
  function automatic logic is_younger(
    input logic    flag_a,
    input robidx_t idx_a,
    input logic    flag_b,
    input robidx_t idx_b
  );
    return (flag_a ^ flag_b) ^ (idx_b < idx_a);
  endfunction

endpackage

// File: rtl/int_issue_queue_entry.sv
// One issue-queue slot: holds the payload and per-source ready bits, snoops
// the writeback ports for wakeups and reports whether a flush kills it.
module int_iq_entry
  import int_issue_queue_pkg::*;
#(
  parameter int WB_PORTS = 2
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_wr,
  input  int_uop_t                        i_wr_uop,
  input  logic                            i_deq,
  input  logic [WB_PORTS-1:0]             i_wb_valid,
  input  logic [WB_PORTS-1:0][PREG_W-1:0] i_wb_prd,
  input  logic                            i_flush_valid,
  input  logic                            i_flush_robidx_flag,
  input  robidx_t                         i_flush_robidx,
  output logic                            o_valid,
  output int_uop_t                        o_uop,
  output logic                            o_kill
);

  logic     r_valid;
  int_uop_t r_uop;

  preg_t    w_prs1;
  preg_t    w_prs2;
  logic     w_wake1;
  logic     w_wake2;
  logic     w_drop;
  int_uop_t w_wr_uop;

  // Any valid writeback of a non-zero register matching prs wakes that source.
  function automatic logic wake_hit(
    input preg_t                           prs,
    input logic [WB_PORTS-1:0]             wbv,
    input logic [WB_PORTS-1:0][PREG_W-1:0] wbp
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < WB_PORTS; i++) begin
      if (wbv[i] && (wbp[i] != {PREG_W{1'b0}}) && (wbp[i] == prs)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Compare against the incoming payload on a write, else the stored one;
  // register 0 is hard-wired so its sources count as ready.
  always_comb begin
    w_prs1 = r_uop.prs1;
    w_prs2 = r_uop.prs2;
    if (i_wr) begin
      w_prs1 = i_wr_uop.prs1;
      w_prs2 = i_wr_uop.prs2;
    end else begin
      w_prs1 = r_uop.prs1;
      w_prs2 = r_uop.prs2;
    end
    w_wake1 = (w_prs1 == {PREG_W{1'b0}}) | wake_hit(w_prs1, i_wb_valid, i_wb_prd);
    w_wake2 = (w_prs2 == {PREG_W{1'b0}}) | wake_hit(w_prs2, i_wb_valid, i_wb_prd);
  end

  // Payload as stored on enqueue, with same-cycle wakeups folded in.
  always_comb begin
    w_wr_uop            = i_wr_uop;
    w_wr_uop.src1_ready = i_wr_uop.src1_ready | w_wake1;
    w_wr_uop.src2_ready = i_wr_uop.src2_ready | w_wake2;
  end

  assign o_kill  = r_valid & i_flush_valid &
                   is_younger(r_uop.robidx_flag, r_uop.robidx,
                              i_flush_robidx_flag, i_flush_robidx);
  assign w_drop  = r_valid & (o_kill | i_deq);
  assign o_valid = r_valid;
  assign o_uop   = r_uop;

  // Slot state: fill on enqueue, release on issue or kill, else accumulate wakeups.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_uop   <= '0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
      r_uop   <= w_wr_uop;
    end else if (w_drop) begin
      r_valid <= 1'b0;
    end else begin
      r_uop.src1_ready <= r_uop.src1_ready | w_wake1;
      r_uop.src2_ready <= r_uop.src2_ready | w_wake2;
    end
  end

endmodule

// File: rtl/int_issue_queue.sv
// In-order integer issue queue: circular FIFO of renamed micro-ops that
// issues the head once both sources are ready and trims younger entries
// on a ROB-index flush.
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WB_PORTS = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enq_valid,
  output logic                            enq_ready,
  input  int_uop_t                        enq_uop,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output int_uop_t                        issue_uop,
  input  logic [WB_PORTS-1:0]             wb_valid,
  input  logic [WB_PORTS-1:0][PREG_W-1:0] wb_prd,
  input  logic                            flush_valid,
  input  logic                            flush_robidx_flag,
  input  robidx_t                         flush_robidx,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Pointers carry one wrap bit above the slot index.
  logic [CNT_W-1:0] r_head;
  logic [CNT_W-1:0] r_tail;

  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;
  logic             w_full;
  logic             w_enq_fire;
  logic             w_deq;
  logic [CNT_W-1:0] w_surv;

  logic [DEPTH-1:0] w_ent_valid;
  logic [DEPTH-1:0] w_ent_kill;
  int_uop_t         w_ent_uop [DEPTH];

  logic             w_head_valid;
  logic             w_head_kill;
  int_uop_t         w_head_uop;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_full     = (w_head_idx == w_tail_idx) & (r_head[IDX_W] != r_tail[IDX_W]);

  // No dequeue bypass: a full queue refuses even if the head leaves this cycle.
  assign enq_ready  = ~w_full & ~flush_valid;
  assign w_enq_fire = enq_valid & enq_ready;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_entry
      int_iq_entry #(
        .WB_PORTS (WB_PORTS)
      ) u_entry (
        .i_clock             (clock),
        .i_reset             (reset),
        .i_wr                (w_enq_fire & (w_tail_idx == IDX_W'(g))),
        .i_wr_uop            (enq_uop),
        .i_deq               (w_deq & (w_head_idx == IDX_W'(g))),
        .i_wb_valid          (wb_valid),
        .i_wb_prd            (wb_prd),
        .i_flush_valid       (flush_valid),
        .i_flush_robidx_flag (flush_robidx_flag),
        .i_flush_robidx      (flush_robidx),
        .o_valid             (w_ent_valid[g]),
        .o_uop               (w_ent_uop[g]),
        .o_kill              (w_ent_kill[g])
      );
    end
  endgenerate

  assign w_head_valid = w_ent_valid[w_head_idx];
  assign w_head_kill  = w_ent_kill[w_head_idx];
  assign w_head_uop   = w_ent_uop[w_head_idx];

  // A killed head never issues; younger entries wait behind a non-ready head.
  assign issue_valid = w_head_valid & w_head_uop.src1_ready &
                       w_head_uop.src2_ready & ~w_head_kill;
  assign w_deq       = issue_valid & issue_ready;

  // Head payload presented to execute with sources reported ready.
  always_comb begin
    issue_uop            = w_head_uop;
    issue_uop.src1_ready = 1'b1;
    issue_uop.src2_ready = 1'b1;
  end

  // Survivors of a flush form a prefix from head, so their count (including a
  // dequeuing head) is exactly the distance from head to the new tail.
  always_comb begin
    w_surv = {CNT_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i] && !w_ent_kill[i]) begin
        w_surv = w_surv + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        w_surv = w_surv;
      end
    end
  end

  // Pointer update: head follows dequeues, tail follows enqueues or is
  // pulled back to the end of the surviving prefix on a flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head <= {CNT_W{1'b0}};
      r_tail <= {CNT_W{1'b0}};
    end else begin
      if (w_deq) begin
        r_head <= r_head + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_head <= r_head;
      end
      if (flush_valid) begin
        r_tail <= r_head + w_surv;
      end else if (w_enq_fire) begin
        r_tail <= r_tail + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_tail <= r_tail;
      end
    end
  end

  assign count = r_tail - r_head;

endmodule

// File: tb/tb_int_issue_queue.sv
// Randomised and directed bench for int_issue_queue with a queue-based
// reference model and a decoupled scoreboard monitor.
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  localparam int DEPTH    = 8;
  localparam int WB_PORTS = 2;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic                            clock = 1'b0;
  logic                            reset;
  logic                            enq_valid;
  logic                            enq_ready;
  int_uop_t                        enq_uop;
  logic                            issue_valid;
  logic                            issue_ready;
  int_uop_t                        issue_uop;
  logic [WB_PORTS-1:0]             wb_valid;
  logic [WB_PORTS-1:0][PREG_W-1:0] wb_prd;
  logic                            flush_valid;
  logic                            flush_robidx_flag;
  robidx_t                         flush_robidx;
  logic [CNT_W-1:0]                count;

  always #5 clock = ~clock;

  int_issue_queue #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS)) dut (
    .clock             (clock),
    .reset             (reset),
    .enq_valid         (enq_valid),
    .enq_ready         (enq_ready),
    .enq_uop           (enq_uop),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_uop         (issue_uop),
    .wb_valid          (wb_valid),
    .wb_prd            (wb_prd),
    .flush_valid       (flush_valid),
    .flush_robidx_flag (flush_robidx_flag),
    .flush_robidx      (flush_robidx),
    .count             (count)
  );

  typedef struct { int_uop_t u; bit r1; bit r2; } m_ent_t;
  typedef struct { bit iv; bit er; int cnt; } stat_t;

  m_ent_t   mq[$];       // reference contents, oldest first
  int_uop_t exp_q[$];    // expected issue stream
  stat_t    stat_q[$];   // expected per-cycle status
  int       n_tests = 0;
  int       n_fail  = 0;
  logic [5:0] rob_ptr = 6'd0;

  // Age relation from the unwrapped 6-bit ROB position: e is younger than f
  // when it lies 1..32 positions after f.
  function automatic bit m_younger(bit ef, robidx_t ei, bit ff, robidx_t fi);
    int d;
    d = (int'({ef, ei}) - int'({ff, fi}) + 64) % 64;
    return (d >= 1) && (d <= 32);
  endfunction

  function automatic bit m_wake(preg_t prs, logic [WB_PORTS-1:0] wv,
                                logic [WB_PORTS-1:0][PREG_W-1:0] wp);
    bit h;
    h = 1'b0;
    for (int i = 0; i < WB_PORTS; i++)
      if (wv[i] && wp[i] != 0 && wp[i] == prs) h = 1'b1;
    return h;
  endfunction

  function automatic int_uop_t rand_uop();
    int_uop_t u;
    u             = '0;
    u.prd         = PREG_W'($urandom_range(0, 63));
    u.prs1        = PREG_W'($urandom_range(0, 15));
    u.prs2        = PREG_W'($urandom_range(0, 15));
    u.src1_ready  = ($urandom_range(0, 3) != 0);
    u.src2_ready  = ($urandom_range(0, 3) != 0);
    u.imm         = $urandom;
    u.need_to_wb  = 1'($urandom_range(0, 1));
    u.cx_type     = 3'($urandom_range(0, 7));
    u.is_unsigned = 1'($urandom_range(0, 1));
    u.alu_type    = 4'($urandom_range(0, 15));
    u.is_word     = 1'($urandom_range(0, 1));
    u.is_imm      = 1'($urandom_range(0, 1));
    u.muldiv_type = 4'($urandom_range(0, 15));
    u.pc          = $urandom;
    u.robidx_flag = rob_ptr[5];
    u.robidx      = rob_ptr[4:0];
    return u;
  endfunction

  task automatic check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, record the model's predictions, advance the model.
  task automatic step(bit ev, int_uop_t u, bit ir, logic [WB_PORTS-1:0] wv,
                      logic [WB_PORTS-1:0][PREG_W-1:0] wp,
                      bit fv, bit ff, robidx_t fi);
    stat_t    s;
    bit       er, iv, kh;
    int_uop_t e;
    m_ent_t   n;
    m_ent_t   keep[$];
    enq_valid = ev; enq_uop = u; issue_ready = ir; wb_valid = wv; wb_prd = wp;
    flush_valid = fv; flush_robidx_flag = ff; flush_robidx = fi;
    er = (mq.size() < DEPTH) && !fv;
    kh = (mq.size() > 0) && fv && m_younger(mq[0].u.robidx_flag, mq[0].u.robidx, ff, fi);
    iv = (mq.size() > 0) && mq[0].r1 && mq[0].r2 && !kh;
    s.iv = iv; s.er = er; s.cnt = mq.size();
    stat_q.push_back(s);
    if (iv && ir) begin
      e = mq[0].u; e.src1_ready = 1'b1; e.src2_ready = 1'b1;
      exp_q.push_back(e);
      void'(mq.pop_front());
    end
    if (fv) begin
      keep = {};
      foreach (mq[i])
        if (!m_younger(mq[i].u.robidx_flag, mq[i].u.robidx, ff, fi)) keep.push_back(mq[i]);
      mq = keep;
    end
    for (int i = 0; i < mq.size(); i++) begin
      mq[i].r1 = mq[i].r1 | m_wake(mq[i].u.prs1, wv, wp);
      mq[i].r2 = mq[i].r2 | m_wake(mq[i].u.prs2, wv, wp);
    end
    if (ev && er) begin
      n.u  = u;
      n.r1 = u.src1_ready || (u.prs1 == 0) || m_wake(u.prs1, wv, wp);
      n.r2 = u.src2_ready || (u.prs2 == 0) || m_wake(u.prs2, wv, wp);
      mq.push_back(n);
      rob_ptr = {u.robidx_flag, u.robidx} + 6'd1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(bit ir);
    step(1'b0, '0, ir, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic enq(int_uop_t u, bit ir);
    step(1'b1, u, ir, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic wake(int port, preg_t p, bit ir);
    logic [WB_PORTS-1:0]             wv;
    logic [WB_PORTS-1:0][PREG_W-1:0] wp;
    wv = '0; wp = '0;
    wv[port] = 1'b1; wp[port] = p;
    step(1'b0, '0, ir, wv, wp, 1'b0, 1'b0, '0);
  endtask

  // Scoreboard monitor: compares status every modelled cycle and the payload
  // on every handshake, away from the active edge.
  always @(negedge clock) begin
    stat_t    s;
    int_uop_t e;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      check("issue_valid", int'(issue_valid), int'(s.iv));
      check("enq_ready", int'(enq_ready), int'(s.er));
      check("count", int'(count), s.cnt);
      if (issue_valid && issue_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL issue_uop: unexpected issue %h, none expected", issue_uop);
        end else begin
          e = exp_q.pop_front();
          if (issue_uop !== e) begin
            n_fail++;
            $display("FAIL issue_uop: got %h, expected %h", issue_uop, e);
          end
        end
      end
    end
  end

  initial begin
    int_uop_t u;
    bit ev, ir, fv;
    logic [WB_PORTS-1:0] wv;
    logic [WB_PORTS-1:0][PREG_W-1:0] wp;
    logic [5:0] tgt;
    int k;

    reset = 1'b1;
    enq_valid = 1'b0; enq_uop = '0; issue_ready = 1'b0; wb_valid = '0; wb_prd = '0;
    flush_valid = 1'b0; flush_robidx_flag = 1'b0; flush_robidx = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_issue_valid", int'(issue_valid), 0);
    check("reset_count", int'(count), 0);
    check("reset_enq_ready", int'(enq_ready), 1);

    // Fill with ready uops while execute stalls, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      u = rand_uop(); u.src1_ready = 1'b1; u.src2_ready = 1'b1;
      enq(u, 1'b0);
    end
    check("fill_count", int'(count), DEPTH);
    check("fill_enq_ready", int'(enq_ready), 0);
    idle(1'b0);
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    check("drain_count", int'(count), 0);

    // Wakeup visible the cycle after the writeback.
    u = rand_uop(); u.prs1 = 6'd5; u.src1_ready = 1'b0; u.prs2 = 6'd0; u.src2_ready = 1'b0;
    enq(u, 1'b1);
    idle(1'b1);
    wake(0, 6'd5, 1'b1);
    check("wake_next_cycle", int'(issue_valid), 1);
    idle(1'b1);

    // Wakeup in the enqueue cycle is captured.
    u = rand_uop(); u.prs2 = 6'd9; u.src2_ready = 1'b0; u.prs1 = 6'd0;
    step(1'b1, u, 1'b1, 2'b10, {6'd9, 6'd0}, 1'b0, 1'b0, '0);
    check("enq_wake_captured", int'(issue_valid), 1);
    idle(1'b1);

    // A blocked head holds back a ready younger entry.
    u = rand_uop(); u.prs1 = 6'd7; u.src1_ready = 1'b0; u.src2_ready = 1'b1;
    enq(u, 1'b1);
    u = rand_uop(); u.src1_ready = 1'b1; u.src2_ready = 1'b1;
    enq(u, 1'b1);
    idle(1'b1); idle(1'b1);
    wake(1, 6'd7, 1'b1);
    repeat (3) idle(1'b1);

    // Flush across the ROB wrap: 30, 31 survive, (1,0) and (1,1) are removed.
    rob_ptr = 6'd30;
    for (int i = 0; i < 4; i++) begin
      u = rand_uop(); u.prs1 = 6'd12; u.src1_ready = 1'b0;
      enq(u, 1'b0);
    end
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd31);
    check("flush_wrap_count", int'(count), 2);
    rob_ptr = 6'd32;
    u = rand_uop(); u.src1_ready = 1'b1; u.src2_ready = 1'b1;
    enq(u, 1'b0);
    check("flush_refill_count", int'(count), 3);
    wake(0, 6'd12, 1'b1);
    repeat (5) idle(1'b1);

    // Randomised traffic with wakeups and flushes.
    for (int c = 0; c < 1500; c++) begin
      ev = ($urandom_range(0, 3) != 0);
      ir = ($urandom_range(0, 2) != 0);
      for (int p = 0; p < WB_PORTS; p++) begin
        wv[p] = ($urandom_range(0, 2) == 0);
        wp[p] = PREG_W'($urandom_range(0, 15));
      end
      fv = ($urandom_range(0, 15) == 0);
      tgt = 6'($urandom);
      if (fv && mq.size() > 0) begin
        k = $urandom_range(0, mq.size());
        if (k == 0) tgt = {mq[0].u.robidx_flag, mq[0].u.robidx} - 6'd1;
        else        tgt = {mq[k-1].u.robidx_flag, mq[k-1].u.robidx};
      end
      step(ev, rand_uop(), ir, wv, wp, fv, tgt[5], tgt[4:0]);
    end

    // Asynchronous reset between edges with entries held.
    for (int p = 0; p < WB_PORTS; p++) wv[p] = 1'b1;
    wp = {6'd1, 6'd2};
    step(1'b0, '0, 1'b1, '0, '0, 1'b1, tgt[5], tgt[4:0]);
    while (mq.size() > 0) step(1'b0, '0, 1'b1, '0, '0, 1'b1,
                               mq[0].u.robidx_flag, mq[0].u.robidx - 5'd1);
    for (int i = 0; i < 5; i++) begin
      u = rand_uop(); u.src1_ready = 1'b1; u.src2_ready = 1'b1;
      enq(u, 1'b0);
    end
    check("pre_reset_count", int'(count), 5);
    #2 reset = 1'b1;
    #1;
    check("async_reset_issue_valid", int'(issue_valid), 0);
    check("async_reset_count", int'(count), 0);
    mq.delete();
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    idle(1'b1);
    u = rand_uop(); u.src1_ready = 1'b1; u.src2_ready = 1'b1;
    enq(u, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("issue_stream_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
